// File: rtl/sm_dividend_rebuild.sv
// Sign-magnitude dividend rebuild a = q*b + r via 4-step shift-add multiply and signed merge.
// Optional REBUILD_CHECK_EN adds the a_exp input and the registered match output.
module sm_dividend_rebuild (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] q,
    input  logic [2:0] b,
    input  logic [4:0] r,
    output logic       busy,
    output logic       done,
    output logic [6:0] a_out,
    output logic       ovf,
    output logic       divbyzeroflag
`ifdef REBUILD_CHECK_EN
    ,
    input  logic [2:0] a_exp,
    output logic       match
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_ADD,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] q_q, q_d;
    logic [2:0] b_q, b_d;
    logic [4:0] r_q, r_d;
    logic [1:0] cnt_q, cnt_d;
    logic [5:0] acc_q, acc_d;
    logic [6:0] a_q, a_d;
    logic       ovf_q, ovf_d;
    logic       dbz_q, dbz_d;
`ifdef REBUILD_CHECK_EN
    logic [2:0] aexp_q, aexp_d;
    logic       match_q, match_d;
    logic       m_match;
`endif

    logic [5:0] addend;
    logic [5:0] r_mag6;
    logic [5:0] m_mag;
    logic       p_sgn;
    logic       m_sgn_raw;
    logic       m_sgn;

    assign addend = {4'b0000, b_q[1:0]} << cnt_q;

    // Product sign is forced positive for a zero product so merges never see -0.
    always_comb begin
        p_sgn  = (q_q[4] ^ b_q[2]) & (acc_q != 6'd0);
        r_mag6 = {2'b00, r_q[3:0]};
        if (p_sgn == r_q[4]) begin
            m_mag     = acc_q + r_mag6;
            m_sgn_raw = p_sgn;
        end else if (acc_q >= r_mag6) begin
            m_mag     = acc_q - r_mag6;
            m_sgn_raw = p_sgn;
        end else begin
            m_mag     = r_mag6 - acc_q;
            m_sgn_raw = r_q[4];
        end
        m_sgn = m_sgn_raw & (m_mag != 6'd0);
    end

`ifdef REBUILD_CHECK_EN
    assign m_match = ((m_sgn == aexp_q[2]) &&
                      (m_mag == {4'b0000, aexp_q[1:0]})) ||
                     ((aexp_q == 3'b100) && (m_mag == 6'd0));
`endif

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
`ifdef REBUILD_CHECK_EN
        aexp_d  = aexp_q;
        match_d = match_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_d   = q;
                    b_d   = b;
                    r_d   = r;
                    cnt_d = 2'd0;
                    acc_d = 6'd0;
                    a_d   = 7'd0;
                    ovf_d = 1'b0;
`ifdef REBUILD_CHECK_EN
                    aexp_d  = a_exp;
                    match_d = 1'b0;
`endif
                    if (b[1:0] == 2'b00) begin
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (q_q[cnt_q]) begin
                    acc_d = acc_q + addend;
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                a_d     = {m_sgn, m_mag};
                ovf_d   = (m_mag > 6'd3);
`ifdef REBUILD_CHECK_EN
                match_d = m_match;
`endif
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            q_q     <= 5'd0;
            b_q     <= 3'd0;
            r_q     <= 5'd0;
            cnt_q   <= 2'd0;
            acc_q   <= 6'd0;
            a_q     <= 7'd0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef REBUILD_CHECK_EN
            aexp_q  <= 3'd0;
            match_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
`ifdef REBUILD_CHECK_EN
            aexp_q  <= aexp_d;
            match_q <= match_d;
`endif
        end
    end

    assign busy          = (state_q == S_MUL) || (state_q == S_ADD);
    assign done          = (state_q == S_DONE);
    assign a_out         = a_q;
    assign ovf           = ovf_q;
    assign divbyzeroflag = dbz_q;
`ifdef REBUILD_CHECK_EN
    assign match         = match_q;
`endif

endmodule

// File: tb/tb_sm_dividend_rebuild.sv
// Directed bench for sm_dividend_rebuild: latency, signed merges, zero divisor,
// overflow, handshake, reset abort and (with REBUILD_CHECK_EN) the match compare.
module tb_sm_dividend_rebuild;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] q;
    logic [2:0] b;
    logic [4:0] r;
    logic       busy;
    logic       done;
    logic [6:0] a_out;
    logic       ovf;
    logic       divbyzeroflag;
    logic [2:0] a_exp;
`ifdef REBUILD_CHECK_EN
    logic       match;
`endif

    int n_checks;
    int n_fail;

    sm_dividend_rebuild dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .q            (q),
        .b            (b),
        .r            (r),
        .busy         (busy),
        .done         (done),
        .a_out        (a_out),
        .ovf          (ovf),
        .divbyzeroflag(divbyzeroflag)
`ifdef REBUILD_CHECK_EN
        ,
        .a_exp        (a_exp),
        .match        (match)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a start for one edge, then scramble operands to prove capture.
    task automatic start_op(input logic [4:0] qi, input logic [2:0] bi,
                            input logic [4:0] ri);
        @(negedge clk);
        q     = qi;
        b     = bi;
        r     = ri;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        q     = 5'h1f;
        b     = 3'b011;
        r     = 5'h0f;
        a_exp = ~a_exp;
    endtask

    task automatic wait_done(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy === 1'b1) nbusy++;
        end while (done !== 1'b1 && lat < 20);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        q     = 5'd0;
        b     = 3'd0;
        r     = 5'd0;
        a_exp = 3'd0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, a_out, ovf, divbyzeroflag} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0",
                     {busy, done, a_out, ovf, divbyzeroflag});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        int lat, nb;
        start_op(5'b0_0001, 3'b010, 5'b0_0001);
        wait_done(lat, nb);
        n_checks++;
        if (lat !== 6 || nb !== 5) begin
            n_fail++;
            $display("FAIL basic_timing: lat=%0d busy=%0d want 6 5", lat, nb);
        end
        n_checks++;
        if (a_out !== 7'b0_000011 || ovf !== 1'b0 || divbyzeroflag !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: a=%b ovf=%b dbz=%b want 0000011 0 0",
                     a_out, ovf, divbyzeroflag);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || a_out !== 7'b0_000011) begin
            n_fail++;
            $display("FAIL basic_hold: done=%b a=%b want 0 0000011", done, a_out);
        end
    endtask

    task automatic test_signed;
        logic [4:0] tq [5];
        logic [2:0] tb [5];
        logic [4:0] tr [5];
        logic [6:0] ta [5];
        logic       to [5];
        int lat, nb;
        tq = '{5'b1_0001, 5'b0_0001, 5'b0_0001, 5'b0_0101, 5'b1_0000};
        tb = '{3'b010,    3'b010,    3'b001,    3'b111,    3'b110};
        tr = '{5'b1_0001, 5'b1_0001, 5'b1_0001, 5'b0_0010, 5'b1_0001};
        ta = '{7'b1_000011, 7'b0_000001, 7'b0_000000, 7'b1_001101, 7'b1_000001};
        to = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            start_op(tq[i], tb[i], tr[i]);
            wait_done(lat, nb);
            n_checks++;
            if (lat !== 6 || a_out !== ta[i] || ovf !== to[i]) begin
                n_fail++;
                $display("FAIL signed_%0d: lat=%0d a=%b ovf=%b want 6 %b %b",
                         i, lat, a_out, ovf, ta[i], to[i]);
            end
        end
    endtask

    task automatic test_divzero;
        logic [2:0] bz [2];
        int lat, nb;
        bz = '{3'b000, 3'b100};
        for (int i = 0; i < 2; i++) begin
            start_op(5'b0_0111, bz[i], 5'b1_0011);
            wait_done(lat, nb);
            n_checks++;
            if (lat !== 1 || nb !== 0) begin
                n_fail++;
                $display("FAIL dbz_timing_%0d: lat=%0d busy=%0d want 1 0", i, lat, nb);
            end
            n_checks++;
            if (divbyzeroflag !== 1'b1 || a_out !== 7'd0 || ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL dbz_result_%0d: dbz=%b a=%b ovf=%b want 1 0 0",
                         i, divbyzeroflag, a_out, ovf);
            end
        end
        start_op(5'b0_0001, 3'b001, 5'b0_0000);
        @(negedge clk);
        n_checks++;
        if (divbyzeroflag !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL dbz_clear: dbz=%b busy=%b want 0 1", divbyzeroflag, busy);
        end
        wait_done(lat, nb);
    endtask

    task automatic test_overflow;
        int lat, nb;
        start_op(5'b0_1111, 3'b011, 5'b0_1111);
        wait_done(lat, nb);
        n_checks++;
        if (lat !== 6 || a_out !== 7'b0_111100 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_result: lat=%0d a=%b ovf=%b want 6 0111100 1",
                     lat, a_out, ovf);
        end
        start_op(5'b0_0001, 3'b001, 5'b0_0000);
        @(negedge clk);
        n_checks++;
        if (a_out !== 7'd0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_clear: a=%b ovf=%b want 0 0", a_out, ovf);
        end
        wait_done(lat, nb);
        n_checks++;
        if (lat !== 5 || a_out !== 7'b0_000001) begin
            n_fail++;
            $display("FAIL after_clear: lat=%0d a=%b want 5 0000001", lat, a_out);
        end
    endtask

    task automatic test_ignore_start;
        int lat, nb, extra;
        start_op(5'b0_0011, 3'b010, 5'b0_0000);
        @(negedge clk);
        start = 1'b1;
        q     = 5'b0_1111;
        b     = 3'b011;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, nb);
        n_checks++;
        if (lat !== 4 || a_out !== 7'b0_000110) begin
            n_fail++;
            $display("FAIL busy_start: lat=%0d a=%b want 4 0000110", lat, a_out);
        end
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL busy_start_queued: extra=%0d want 0", extra);
        end
    endtask

    task automatic test_reset_mid;
        int extra;
        start_op(5'b0_0001, 3'b010, 5'b0_0001);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || a_out !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b a=%b want 0 0 0",
                     busy, done, a_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_done: extra=%0d want 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        int lat, nb;
        start_op(5'b0_0010, 3'b011, 5'b0_0001);
        wait_done(lat, nb);
        q     = 5'b1_0001;
        b     = 3'b001;
        r     = 5'b0_0000;
        start = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || a_out !== 7'b0_000111) begin
            n_fail++;
            $display("FAIL b2b_done_ignored: busy=%b a=%b want 0 0000111", busy, a_out);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, nb);
        n_checks++;
        if (lat !== 6 || nb !== 5 || a_out !== 7'b1_000001) begin
            n_fail++;
            $display("FAIL b2b_second: lat=%0d busy=%0d a=%b want 6 5 1000001",
                     lat, nb, a_out);
        end
    endtask

`ifdef REBUILD_CHECK_EN
    task automatic test_match;
        logic [2:0] te [3];
        logic [4:0] tq [3];
        logic       tm [3];
        int lat, nb;
        te = '{3'b011, 3'b111, 3'b100};
        tq = '{5'b0_0001, 5'b0_0001, 5'b0_0000};
        tm = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            a_exp = te[i];
            start_op(tq[i], 3'b011, 5'b0_0000);
            wait_done(lat, nb);
            n_checks++;
            if (match !== tm[i]) begin
                n_fail++;
                $display("FAIL match_%0d: got %b want %b", i, match, tm[i]);
            end
        end
        a_exp = 3'b000;
        start_op(5'b0_0001, 3'b100, 5'b0_0000);
        wait_done(lat, nb);
        n_checks++;
        if (match !== 1'b0) begin
            n_fail++;
            $display("FAIL match_dbz: got %b want 0", match);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_signed();
        test_divzero();
        test_overflow();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
`ifdef REBUILD_CHECK_EN
        test_match();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sm_dividend_rebuild.md
# sm_dividend_rebuild

Sequential sign-magnitude dividend reconstructor for the 3-bit signed calculator. It takes a quotient, divisor and remainder and rebuilds the dividend as a = q·b + r, using iterative shift-add multiplication followed by a signed merge. It is the inverse of the remainder/division path and serves as an in-design self-check of the divider results. A start/busy/done handshake accepts one operation at a time.

## Interface
Parameters:
- none (all widths are fixed by the 3-bit calculator format)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- q  input  5  quotient, sign-magnitude: [4] sign, [3:0] magnitude
- b  input  3  divisor, sign-magnitude: [2] sign, [1:0] magnitude
- r  input  5  remainder, sign-magnitude: [4] sign, [3:0] magnitude
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when the result is valid
- a_out  output  7  rebuilt dividend, sign-magnitude: [6] sign, [5:0] magnitude
- ovf  output  1  |a_out| > 3, so the result is not a valid 3-bit operand
- divbyzeroflag  output  1  b magnitude was zero; no result is produced
- a_exp  input  3  expected dividend (only with REBUILD_CHECK_EN)
- match  output  1  a_out equals a_exp (only with REBUILD_CHECK_EN)

## Operation
- Reset value of every output is 0, and the FSM resets to IDLE.
- q, b and r are captured into internal registers on the accepting edge. Later input changes have no effect.
- States and transitions:
  - IDLE: start=1 and b[1:0]≠0 → MUL; start=1 and b[1:0]=0 → DONE with divbyzeroflag=1.
  - MUL: four iterations, one per q magnitude bit, LSB first. Each iteration adds (b_mag << i) to an accumulator when q_mag[i]=1. After the 4th iteration → ADD.
  - ADD: merges the product and r into a_out → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Product arithmetic:
  - Magnitude is at most 15·3 = 45 (6 bits).
  - Sign is q[4]^b[2], forced to 0 when the magnitude is 0.
- Merge arithmetic:
  - Equal signs: add the magnitudes and keep the common sign.
  - Different signs: subtract the smaller magnitude from the larger; the sign is that of the larger.
  - A zero result always has sign 0 (no negative zero).
  - Maximum magnitude is 45+15 = 60, which never overflows the 6-bit field.
- Output registers:
  - a_out, ovf, divbyzeroflag and match are registered at the ADD→DONE transition (or at IDLE→DONE for a zero divisor).
  - They hold their values until the next accepted start, then clear to 0 on that accepting edge.
- Divide-by-zero: a_out=0, ovf=0, divbyzeroflag=1. Both b=000 and b=100 count as zero.
- start while busy is ignored and is not queued. start is also ignored in the DONE cycle.
- Reset mid-operation: the FSM returns to IDLE immediately and all outputs go to 0. No done pulse is produced for the aborted operation.

## Timing
- Start accepted at edge N (in IDLE):
  - busy is high for cycles N+1 … N+5.
  - MUL occupies N+1 … N+4; ADD occupies N+5.
  - done is high during the cycle following edge N+5, with the result valid in that cycle.
- Zero divisor: done is high in the cycle after edge N. busy stays 0.
- Back-to-back: the earliest next accept is the first IDLE cycle after done. Throughput is one operation per 7 cycles.

## Configuration
- REBUILD_CHECK_EN defined:
  - a_exp and match ports exist. a_exp is captured with the other operands.
  - match = (a_out[6]==a_exp[2]) && (a_out[5:0]=={4'b0,a_exp[1:0]}).
  - match is registered with a_out and is forced to 0 on divide-by-zero.
  - As a special case, a_exp=100 (-0) matches a_out=0.
- REBUILD_CHECK_EN not defined: the ports, capture register and comparator are absent. All other behaviour is identical.

## Test plan
- Basic rebuild: q=0_0001, b=010, r=0_0001, start pulse → busy for 5 cycles, then done 1 cycle with a_out=0_000011, ovf=0, divbyzeroflag=0.
- Signed merges:
  - q=1_0001, b=010, r=1_0001 → a_out=1_000011.
  - q=0_0001, b=010, r=1_0001 → a_out=0_000001.
  - q=0_0001, b=001, r=1_0001 → a_out=0_000000 (sign 0).
- Divide-by-zero: b=000, then b=100, any q/r → done one cycle after start, busy never high, divbyzeroflag=1, a_out=0.
- Overflow: q=0_1111, b=011, r=0_1111 → a_out=0_111100, ovf=1.
- Handshake and reset:
  - start re-asserted during MUL → ignored; a single done occurs at N+5.
  - rst_n pulled low at N+2 → busy=0, done=0, a_out=0 immediately; no done follows.
- With REBUILD_CHECK_EN:
  - q=0_0001, b=011, r=0_0000, a_exp=011 → match=1.
  - Same operands with a_exp=111 → match=0.
